// File: rtl/ad7476a_emulator.sv
// ---------------------------------------------------------------------------
// ad7476a_emulator
//
// Slave-side model of the AD7476A 12-bit ADC serial port. The master's
// sclk/cs_n are brought into the clk_i domain through synchronizers and
// edge-detected. A falling cs_n latches the holding register into a shift
// register that presents LEADING_ZEROS zeros followed by DATA_BITS data bits,
// MSB first, advancing one bit per sclk falling edge.
//
// Ports:
//   clk_i          system clock (>= 8x sclk_i)
//   rst_ni         asynchronous active-low reset
//   sclk_i         SPI clock from master (asynchronous)
//   cs_n_i         active-low chip select from master (asynchronous)
//   sdata_o        serial data to master
//   sdata_oe_o     output enable for sdata_o (0 = tri-stated at the pad)
//   sample_i       next conversion value
//   sample_valid_i loads sample_i into the holding register
//   busy_o         high from frame start until cs_n returns high
//   frame_done_o   one-cycle pulse after the last bit's falling edge
//   frame_abort_o  one-cycle pulse when cs_n rises mid-frame
// ---------------------------------------------------------------------------
module ad7476a_emulator #(
    parameter int SYNC_STAGES   = 2,
    parameter int LEADING_ZEROS = 4,
    parameter int DATA_BITS     = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sclk_i,
    input  logic                 cs_n_i,
    output logic                 sdata_o,
    output logic                 sdata_oe_o,
    input  logic [DATA_BITS-1:0] sample_i,
    input  logic                 sample_valid_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 frame_abort_o
);

    localparam int N     = LEADING_ZEROS + DATA_BITS;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sclk_sync_p0, cs_sync_p0;
    logic                   sclk_prev_p1, cs_prev_p1;
    logic                   sclk_s, cs_s;
    logic                   cs_fall, cs_rise, sclk_fall;
    logic [DATA_BITS-1:0]   hold, load_val;
    logic [N-1:0]           shift, shift_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   oe_n, busy_n, done_n, abort_n;

    // Synchronizer stage; idle levels (sclk=1, cs_n=1) after reset so that
    // releasing reset never fabricates an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_p0 <= '1;
            cs_sync_p0   <= '1;
            sclk_prev_p1 <= 1'b1;
            cs_prev_p1   <= 1'b1;
        end else begin
            sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], sclk_i};
            cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], cs_n_i};
            sclk_prev_p1 <= sclk_s;
            cs_prev_p1   <= cs_s;
        end
    end

    // Edge detection stage
    assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
    assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_p1 & ~cs_s;
    assign cs_rise   = ~cs_prev_p1 & cs_s;
    assign sclk_fall = sclk_prev_p1 & ~sclk_s & ~cs_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold <= '0;
        end else if (sample_valid_i) begin
            hold <= sample_i;
        end
    end

    // A sample arriving in the same cycle as the frame start is the one sent.
    assign load_val = sample_valid_i ? sample_i : hold;

    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = cnt;
        oe_n    = sdata_oe_o;
        busy_n  = busy_o;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    shift_n = N'(load_val);
                    cnt_n   = '0;
                    oe_n    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // cs_rise takes priority over a coincident sclk fall.
                if (cs_rise) begin
                    shift_n = '0;
                    oe_n    = 1'b0;
                    busy_n  = 1'b0;
                    abort_n = 1'b1;
                    state_n = IDLE;
                end else if (sclk_fall) begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt < CNT_W'(N - 1)) begin
                        shift_n = {shift[N-2:0], 1'b0};
                    end else begin
                        shift_n = '0;
                        oe_n    = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                shift_n = '0;
                oe_n    = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // Output register stage; shift MSB drives the pin directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            shift         <= '0;
            cnt           <= '0;
            sdata_oe_o    <= 1'b0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_abort_o <= 1'b0;
        end else begin
            state         <= state_n;
            shift         <= shift_n;
            cnt           <= cnt_n;
            sdata_oe_o    <= oe_n;
            busy_o        <= busy_n;
            frame_done_o  <= done_n;
            frame_abort_o <= abort_n;
        end
    end

    assign sdata_o = shift[N-1];

endmodule
